// File: rtl/qed_consistency_monitor.sv
// QED consistency monitor: counts original/duplicate commits and, once quiesced with equal
// counts, sweeps reg[j] vs reg[j+SPLIT]. Optional macro QED_ZERO_CHECK_EN also checks pair 0 is zero.
module qed_consistency_monitor #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int SPLIT = NREGS / 2,
    parameter int CNT_W = 16,
    parameter int LANES = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREGS*XLEN-1:0]    regfile_i,
    input  logic                     commit_valid_i,
    input  logic                     commit_is_dup_i,
    input  logic                     quiesced_i,
    input  logic                     clear_i,
    output logic [CNT_W-1:0]         num_orig_o,
    output logic [CNT_W-1:0]         num_dup_o,
    output logic                     check_busy_o,
    output logic                     check_done_o,
    output logic                     check_pass_o,
    output logic                     mismatch_o,
    output logic [$clog2(NREGS)-1:0] mismatch_idx_o,
    output logic                     overflow_o
);
    localparam int IDX_W = $clog2(NREGS);
    localparam int SW_W  = IDX_W + 1;
`ifdef QED_ZERO_CHECK_EN
    localparam logic [SW_W-1:0] FIRST_IDX = '0;
`else
    localparam logic [SW_W-1:0] FIRST_IDX = SW_W'(1);
`endif
    localparam logic [SW_W-1:0] SPLIT_W = SW_W'(SPLIT);
    localparam logic [SW_W-1:0] LANES_W = SW_W'(LANES);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

    state_e           state_q, state_d;
    logic [SW_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] num_orig_q, num_orig_d, num_dup_q, num_dup_d;
    logic             checked_q, checked_d, pass_q, pass_d;
    logic             mismatch_q, mismatch_d, overflow_q, overflow_d;
    logic [IDX_W-1:0] mm_idx_q, mm_idx_d;

    logic [XLEN-1:0]  regs [NREGS];
    logic [LANES-1:0] lane_fail;
    logic [IDX_W-1:0] lane_j [LANES];
    logic             any_fail;
    logic [IDX_W-1:0] first_fail;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_unpack
        assign regs[gi] = regfile_i[gi*XLEN +: XLEN];
    end

    // Lanes past the original partition are masked; their index is clamped to keep reads in range.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [SW_W-1:0]  j_full;
        logic             in_range;
        logic [IDX_W-1:0] ja, jb;
        assign j_full     = idx_q + SW_W'(gi);
        assign in_range   = j_full < SPLIT_W;
        assign ja         = in_range ? j_full[IDX_W-1:0] : '0;
        assign jb         = ja + IDX_W'(SPLIT);
        assign lane_j[gi] = ja;
`ifdef QED_ZERO_CHECK_EN
        assign lane_fail[gi] = in_range && ((ja == '0) ? ((regs[ja] != '0) || (regs[jb] != '0))
                                                       : (regs[ja] != regs[jb]));
`else
        assign lane_fail[gi] = in_range && (regs[ja] != regs[jb]);
`endif
    end

    always_comb begin
        any_fail   = |lane_fail;
        first_fail = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_fail[i]) first_fail = lane_j[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_orig_d = num_orig_q;
        num_dup_d  = num_dup_q;
        checked_d  = checked_q;
        pass_d     = pass_q;
        mismatch_d = mismatch_q;
        overflow_d = overflow_q;
        mm_idx_d   = mm_idx_q;

        if (commit_valid_i) begin
            checked_d = 1'b0;
            if (commit_is_dup_i) begin
                if (&num_dup_q) overflow_d = 1'b1;
                else            num_dup_d  = num_dup_q + CNT_W'(1);
            end else begin
                if (&num_orig_q) overflow_d = 1'b1;
                else             num_orig_d = num_orig_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (quiesced_i && !commit_valid_i && !checked_q && !overflow_q &&
                    (num_orig_q == num_dup_q) && (num_orig_q != '0)) begin
                    state_d = SWEEP;
                    idx_d   = FIRST_IDX;
                end
            end
            SWEEP: begin
                if (!quiesced_i || commit_valid_i) begin
                    state_d = IDLE;
                end else if (any_fail) begin
                    state_d    = DONE;
                    pass_d     = 1'b0;
                    mismatch_d = 1'b1;
                    mm_idx_d   = first_fail;
                    checked_d  = 1'b1;
                end else if (idx_q + LANES_W >= SPLIT_W) begin
                    state_d   = DONE;
                    pass_d    = 1'b1;
                    checked_d = 1'b1;
                end else begin
                    idx_d = idx_q + LANES_W;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d    = IDLE;
            num_orig_d = '0;
            num_dup_d  = '0;
            checked_d  = 1'b0;
            pass_d     = 1'b0;
            mismatch_d = 1'b0;
            overflow_d = 1'b0;
            mm_idx_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            num_orig_q <= '0;
            num_dup_q  <= '0;
            checked_q  <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
            overflow_q <= 1'b0;
            mm_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_orig_q <= num_orig_d;
            num_dup_q  <= num_dup_d;
            checked_q  <= checked_d;
            pass_q     <= pass_d;
            mismatch_q <= mismatch_d;
            overflow_q <= overflow_d;
            mm_idx_q   <= mm_idx_d;
        end
    end

    assign num_orig_o     = num_orig_q;
    assign num_dup_o      = num_dup_q;
    assign check_busy_o   = (state_q == SWEEP);
    assign check_done_o   = (state_q == DONE);
    assign check_pass_o   = pass_q;
    assign mismatch_o     = mismatch_q;
    assign mismatch_idx_o = mm_idx_q;
    assign overflow_o     = overflow_q;
endmodule
